// File: rtl/submodulo_3.sv
// Setpoint editor driven by the long-press (A) and short-press (B) flags.
// A long press enters or commits an edit; a short press steps the working value; an idle edit times out.
module submodulo_3 #(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = 9,
    parameter int INIT_VAL  = 0,
    parameter int TIMEOUT_T = 20000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    output logic             mode,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] edit_value,
    output logic             commit,
    output logic             timeout
);

    localparam int TW = $clog2(TIMEOUT_T);

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        CONFIG = 2'b01,
        COMMIT = 2'b10
    } state_t;

    state_t           r_state;
    logic             r_a_q;
    logic             r_b_q;
    logic [TW-1:0]    r_timer;
    logic             r_mode;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] r_edit;
    logic             r_commit;
    logic             r_timeout;

    state_t           w_state_nxt;
    logic [TW-1:0]    w_timer_nxt;
    logic [WIDTH-1:0] w_value_nxt;
    logic [WIDTH-1:0] w_edit_nxt;
    logic             w_commit_nxt;
    logic             w_timeout_nxt;
    logic             w_a_ev;
    logic             w_b_ev;

    // A held high for many cycles must produce a single event.
    assign w_a_ev = A & ~r_a_q;
    assign w_b_ev = B & ~r_b_q;

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_value_nxt   = r_value;
        w_edit_nxt    = r_edit;
        w_commit_nxt  = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            NORMAL: begin
                if (w_a_ev) begin
                    w_state_nxt = CONFIG;
                    w_edit_nxt  = r_value;
                    w_timer_nxt = '0;
                end
            end
            CONFIG: begin
                if (w_a_ev) begin
                    w_state_nxt = COMMIT;
                end else if (w_b_ev) begin
                    w_edit_nxt  = (r_edit == WIDTH'(MAX_VAL)) ? '0 : r_edit + WIDTH'(1);
                    w_timer_nxt = '0;
                end else if (r_timer == TW'(TIMEOUT_T - 1)) begin
                    w_state_nxt   = NORMAL;
                    w_timeout_nxt = 1'b1;
                    w_edit_nxt    = r_value;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            COMMIT: begin
                w_value_nxt  = r_edit;
                w_commit_nxt = 1'b1;
                w_state_nxt  = NORMAL;
            end
            default: begin
                w_state_nxt = NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= NORMAL;
            r_a_q     <= 1'b0;
            r_b_q     <= 1'b0;
            r_timer   <= '0;
            r_mode    <= 1'b0;
            r_value   <= WIDTH'(INIT_VAL);
            r_edit    <= WIDTH'(INIT_VAL);
            r_commit  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_a_q     <= A;
            r_b_q     <= B;
            r_timer   <= w_timer_nxt;
            r_mode    <= (w_state_nxt != NORMAL);
            r_value   <= w_value_nxt;
            r_edit    <= w_edit_nxt;
            r_commit  <= w_commit_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign mode       = r_mode;
    assign value      = r_value;
    assign edit_value = r_edit;
    assign commit     = r_commit;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_submodulo_3.sv
// Directed bench for the setpoint editor with MAX_VAL=9, TIMEOUT_T=20, INIT_VAL=0.
module tb_submodulo_3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       A   = 1'b0;
    logic       B   = 1'b0;
    logic       mode;
    logic [3:0] value;
    logic [3:0] edit_value;
    logic       commit;
    logic       timeout;

    int n_checks = 0;
    int n_err    = 0;
    int n_commit = 0;
    int n_to     = 0;
    int n_both   = 0;

    submodulo_3 #(
        .WIDTH    (4),
        .MAX_VAL  (9),
        .INIT_VAL (0),
        .TIMEOUT_T(20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .mode      (mode),
        .value     (value),
        .edit_value(edit_value),
        .commit    (commit),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, one count per high cycle.
    always @(negedge clk) begin
        if (commit) n_commit++;
        if (timeout) n_to++;
        if (commit && timeout) n_both++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press_a();
        A = 1'b1;
        tick(1);
        A = 1'b0;
        tick(1);
    endtask

    task automatic press_b();
        B = 1'b1;
        tick(1);
        B = 1'b0;
        tick(1);
    endtask

    initial begin
        // 1. reset, with flags toggled while held in reset
        tick(2);
        A = 1'b1; tick(1);
        A = 1'b0; B = 1'b1; tick(1);
        B = 1'b0; tick(1);
        chk("rst_value", 32'(value), 0);
        chk("rst_edit", 32'(edit_value), 0);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_commit_cnt", n_commit, 0);
        chk("rst_timeout_cnt", n_to, 0);
        rst = 1'b1;
        tick(1);

        // 2. A held 5 cycles gives one entry, three steps, commit
        A = 1'b1; tick(1);
        chk("t2_mode_enter", 32'(mode), 1);
        tick(4);
        A = 1'b0;
        chk("t2_mode_held", 32'(mode), 1);
        press_b(); press_b(); press_b();
        chk("t2_edit3", 32'(edit_value), 3);
        chk("t2_value_unchanged", 32'(value), 0);
        press_a();
        chk("t2_commit_pulse", 32'(commit), 1);
        tick(1);
        chk("t2_commit_gone", 32'(commit), 0);
        chk("t2_value3", 32'(value), 3);
        chk("t2_mode_exit", 32'(mode), 0);
        chk("t2_commit_cnt", n_commit, 1);

        // 3. wrap at MAX_VAL
        press_a();
        repeat (5) press_b();
        chk("t3_edit8", 32'(edit_value), 8);
        press_b(); chk("t3_edit9", 32'(edit_value), 9);
        press_b(); chk("t3_edit0", 32'(edit_value), 0);
        press_b(); chk("t3_edit1", 32'(edit_value), 1);
        press_a(); tick(1);
        chk("t3_value1", 32'(value), 1);
        chk("t3_commit_cnt", n_commit, 2);

        // 4. set value=4, then abandon an edit by inactivity
        press_a();
        repeat (3) press_b();
        press_a(); tick(1);
        chk("t4_value4", 32'(value), 4);
        press_a();
        press_b();
        chk("t4_edit5", 32'(edit_value), 5);
        tick(18);
        chk("t4_no_timeout_yet", n_to, 0);
        chk("t4_mode_before", 32'(mode), 1);
        tick(1);
        chk("t4_timeout_pulse", 32'(timeout), 1);
        chk("t4_mode_after", 32'(mode), 0);
        chk("t4_value_kept", 32'(value), 4);
        chk("t4_edit_restored", 32'(edit_value), 4);
        tick(2);
        chk("t4_timeout_cnt", n_to, 1);
        chk("t4_commit_cnt", n_commit, 3);

        // 5. B event on the expiry cycle wins; then A and B together commit
        A = 1'b1; tick(1);
        A = 1'b0;
        tick(19);
        B = 1'b1; tick(1);
        B = 1'b0;
        chk("t5_no_timeout", n_to, 1);
        chk("t5_mode_kept", 32'(mode), 1);
        chk("t5_edit5", 32'(edit_value), 5);
        tick(19);
        chk("t5_timer_restarted", 32'(mode), 1);
        A = 1'b1; B = 1'b1; tick(1);
        A = 1'b0; B = 1'b0; tick(1);
        chk("t5_commit_pulse", 32'(commit), 1);
        chk("t5_value5", 32'(value), 5);
        chk("t5_edit_no_step", 32'(edit_value), 5);
        chk("t5_timeout_cnt", n_to, 1);

        // 6. B ignored in NORMAL; reset mid-edit
        tick(1);
        press_b();
        chk("t6_normal_value", 32'(value), 5);
        chk("t6_normal_edit", 32'(edit_value), 5);
        chk("t6_normal_mode", 32'(mode), 0);
        press_a();
        press_b(); press_b();
        chk("t6_edit7", 32'(edit_value), 7);
        rst = 1'b0; tick(1);
        chk("t6_rst_mode", 32'(mode), 0);
        chk("t6_rst_value", 32'(value), 0);
        chk("t6_rst_edit", 32'(edit_value), 0);
        rst = 1'b1; tick(2);
        chk("final_commit_cnt", n_commit, 4);
        chk("final_timeout_cnt", n_to, 1);
        chk("final_never_both", n_both, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
